keypad_matrix_emulator: RTL and testbench

//  Synthesizable model of the 4x3 key matrix seen by the keypad scanner: takes "press key N" commands,

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_matrix_emulator_if.sv | 22 ++
 rtl/keypad_hold_timer.sv | 27 ++
 rtl/keypad_matrix_emulator.sv | 105 ++++++++++
 tb/tb_keypad_matrix_emulator.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix one-hot encodings, key index limits and emulator states.
package keypad_pkg;

    localparam logic [3:0] ROW_ONEHOT [0:3] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    localparam logic [2:0] COL_ONEHOT [0:2] = '{3'b100, 3'b010, 3'b001};
    localparam logic [3:0] KEY_IDX_MAX = 4'd11;

    typedef enum logic [1:0] {
        StIdle,
        StPress,
        StRelease
    } emu_state_e;

    function automatic logic [1:0] idx_to_row(input logic [3:0] idx);
        return 2'(idx / 4'd3);
    endfunction

    function automatic logic [1:0] idx_to_col(input logic [3:0] idx);
        return 2'(idx % 4'd3);
    endfunction

endpackage

// File: rtl/keypad_matrix_emulator_if.sv
// Command handshake, matrix lines and status of the keypad matrix emulator.
interface keypad_matrix_emulator_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_key;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic       busy;
    logic       done;
    logic       cmd_err;
    logic [7:0] press_count;

    modport master (
        output cmd_valid, cmd_key, key_row,
        input  cmd_ready, key_col, busy, done, cmd_err, press_count
    );

    modport slave (
        input  cmd_valid, cmd_key, key_row,
        output cmd_ready, key_col, busy, done, cmd_err, press_count
    );
endinterface

// File: rtl/keypad_hold_timer.sv
// Loadable down-counter that saturates at zero; zero flag marks the last cycle of a phase.
module keypad_hold_timer #(
    parameter int unsigned Width = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             count_en,
    output logic             zero
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (count_en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Emulates one pressed switch of a 4x3 key matrix: press for HOLD_CYCLES, release for GAP_CYCLES.
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 8
) (
    input logic                     clk,
    input logic                     rst,
    keypad_matrix_emulator_if.slave bus
);

    localparam int unsigned MaxCycles  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned TimerWidth = $clog2(MaxCycles + 1);
    localparam logic [TimerWidth-1:0] HoldLoad = TimerWidth'(HOLD_CYCLES - 1);
    localparam logic [TimerWidth-1:0] GapLoad  = TimerWidth'(GAP_CYCLES - 1);

    emu_state_e               state_q;
    logic [1:0]               row_q;
    logic [1:0]               col_q;
    logic                     done_q;
    logic                     cmd_err_q;
    logic [7:0]               press_count_q;
    logic                     cmd_fire;
    logic                     cmd_legal;
    logic                     timer_load;
    logic [TimerWidth-1:0]    timer_load_val;
    logic                     timer_zero;

    assign cmd_fire  = bus.cmd_valid && (state_q == StIdle);
    assign cmd_legal = (bus.cmd_key <= KEY_IDX_MAX);

    always_comb begin
        timer_load     = 1'b0;
        timer_load_val = HoldLoad;
        if (cmd_fire && cmd_legal) begin
            timer_load = 1'b1;
        end else if ((state_q == StPress) && timer_zero) begin
            timer_load     = 1'b1;
            timer_load_val = GapLoad;
        end
    end

    keypad_hold_timer #(
        .Width (TimerWidth)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .count_en (state_q != StIdle),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            row_q         <= 2'd0;
            col_q         <= 2'd0;
            done_q        <= 1'b0;
            cmd_err_q     <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_fire) begin
                        if (cmd_legal) begin
                            row_q   <= idx_to_row(bus.cmd_key);
                            col_q   <= idx_to_col(bus.cmd_key);
                            state_q <= StPress;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                end
                StPress: begin
                    if (timer_zero) begin
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    if (timer_zero) begin
                        state_q       <= StIdle;
                        done_q        <= 1'b1;
                        press_count_q <= press_count_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Contact closes only while the scanner drives exactly the latched row.
    assign bus.key_col = ((state_q == StPress) && (bus.key_row == ROW_ONEHOT[row_q]))
                         ? COL_ONEHOT[col_q] : 3'b000;

    assign bus.cmd_ready   = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.cmd_err     = cmd_err_q;
    assign bus.press_count = press_count_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Self-checking bench for keypad_matrix_emulator with HOLD_CYCLES=16, GAP_CYCLES=8.
module tb_keypad_matrix_emulator;

    typedef struct {
        logic [3:0] key;
        bit         legal;
        logic [3:0] erow;
        logic [2:0] ecol;
    } vec_t;

    typedef struct {
        logic [2:0] col;
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [7:0] m_count;
    bit   pend_done;
    bit   rot_en;
    logic [3:0] row_pat [16];
    exp_t sb[$];
    vec_t vecs [10];

    keypad_matrix_emulator_if bus ();

    keypad_matrix_emulator #(
        .HOLD_CYCLES (16),
        .GAP_CYCLES  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rot_en) bus.key_row = {bus.key_row[0], bus.key_row[3:1]};
    endtask

    task automatic check(input logic [2:0] ecol, input logic ebusy, input logic edone,
                         input logic eerr);
        exp_t e;
        e.col  = ecol;
        e.busy = ebusy;
        e.done = edone;
        e.err  = eerr;
        e.cnt  = m_count;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        cmp("key_col", {5'd0, bus.key_col}, {5'd0, e.col});
        cmp("busy", {7'd0, bus.busy}, {7'd0, e.busy});
        cmp("cmd_ready", {7'd0, bus.cmd_ready}, {7'd0, ~e.busy});
        cmp("done", {7'd0, bus.done}, {7'd0, e.done});
        cmp("cmd_err", {7'd0, bus.cmd_err}, {7'd0, e.err});
        cmp("press_count", bus.press_count, e.cnt);
    endtask

    task automatic idle_cycle();
        check(3'b000, 1'b0, pend_done, 1'b0);
        pend_done = 1'b0;
        step();
    endtask

    task automatic press(input logic [3:0] key, input logic [3:0] erow, input logic [2:0] ecol,
                         input bit keep, input logic [3:0] next_key);
        bus.cmd_valid = 1'b1;
        bus.cmd_key   = key;
        check(3'b000, 1'b0, pend_done, 1'b0);
        pend_done = 1'b0;
        step();
        if (keep) bus.cmd_key = next_key;
        else bus.cmd_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!rot_en) bus.key_row = row_pat[i];
            check((bus.key_row == erow) ? ecol : 3'b000, 1'b1, 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            check(3'b000, 1'b1, 1'b0, 1'b0);
            step();
        end
        m_count   = m_count + 8'd1;
        pend_done = 1'b1;
    endtask

    task automatic illegal(input logic [3:0] key);
        bus.cmd_valid = 1'b1;
        bus.cmd_key   = key;
        check(3'b000, 1'b0, pend_done, 1'b0);
        pend_done = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        check(3'b000, 1'b0, 1'b0, 1'b1);
        step();
        check(3'b000, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        vecs[0] = '{key: 4'd4,  legal: 1'b1, erow: 4'b0100, ecol: 3'b010};
        vecs[1] = '{key: 4'd13, legal: 1'b0, erow: 4'b0000, ecol: 3'b000};
        vecs[2] = '{key: 4'd0,  legal: 1'b1, erow: 4'b1000, ecol: 3'b100};
        vecs[3] = '{key: 4'd11, legal: 1'b1, erow: 4'b0001, ecol: 3'b001};
        vecs[4] = '{key: 4'd7,  legal: 1'b1, erow: 4'b0010, ecol: 3'b010};
        vecs[5] = '{key: 4'd5,  legal: 1'b1, erow: 4'b0100, ecol: 3'b001};
        vecs[6] = '{key: 4'd12, legal: 1'b0, erow: 4'b0000, ecol: 3'b000};
        vecs[7] = '{key: 4'd9,  legal: 1'b1, erow: 4'b0001, ecol: 3'b100};
        vecs[8] = '{key: 4'd15, legal: 1'b0, erow: 4'b0000, ecol: 3'b000};
        vecs[9] = '{key: 4'd2,  legal: 1'b1, erow: 4'b1000, ecol: 3'b001};

        row_pat = '{4'b1100, 4'b0000, 4'b1000, 4'b0100, 4'b1000, 4'b0010, 4'b1000, 4'b0001,
                    4'b1010, 4'b1000, 4'b1111, 4'b1000, 4'b0000, 4'b1000, 4'b1001, 4'b1000};

        checks        = 0;
        errors        = 0;
        m_count       = 8'd0;
        pend_done     = 1'b0;
        rot_en        = 1'b1;
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_key   = 4'd0;
        bus.key_row   = 4'b1000;

        // Reset state
        step();
        idle_cycle();
        rst = 1'b1;
        idle_cycle();

        // Reset asserted mid-press: contact opens without a clock edge, no done, no count
        bus.cmd_valid = 1'b1;
        bus.cmd_key   = 4'd0;
        check(3'b000, 1'b0, 1'b0, 1'b0);
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4 && bus.key_row != 4'b1000; i++) begin
            check(3'b000, 1'b1, 1'b0, 1'b0);
            step();
        end
        #1;
        cmp("col_before_reset", {5'd0, bus.key_col}, 8'h04);
        rst = 1'b0;
        #1;
        cmp("col_async_reset", {5'd0, bus.key_col}, 8'h00);
        cmp("ready_async_reset", {7'd0, bus.cmd_ready}, 8'h01);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 30; i++) idle_cycle();

        // Table of single commands
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].legal) press(vecs[v].key, vecs[v].erow, vecs[v].ecol, 1'b0, 4'd0);
            else illegal(vecs[v].key);
            idle_cycle();
            idle_cycle();
        end

        // cmd_valid held: key 11 transfers in the done cycle of key 0
        press(4'd0, 4'b1000, 3'b100, 1'b1, 4'd11);
        press(4'd11, 4'b0001, 3'b001, 1'b0, 4'd0);
        idle_cycle();
        idle_cycle();

        // Non-one-hot and absent row drive during a press of key 0
        rot_en = 1'b0;
        press(4'd0, 4'b1000, 3'b100, 1'b0, 4'd0);
        idle_cycle();
        rot_en      = 1'b1;
        bus.key_row = 4'b1000;

        // Count up to 255 back to back, then one more press wraps to 0
        while (m_count != 8'd255) press(4'd8, 4'b0010, 3'b001, 1'b0, 4'd0);
        idle_cycle();
        press(4'd3, 4'b0100, 3'b100, 1'b0, 4'd0);
        idle_cycle();
        idle_cycle();
        cmp("count_wrapped", bus.press_count, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
